// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, status codes and response byte helper for the UART command sequencer
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RX_SEL    = 4'd1,
        RX_HI     = 4'd2,
        RX_LO     = 4'd3,
        RX_CHK    = 4'd4,
        CPU_START = 4'd5,
        CPU_WAIT  = 4'd6,
        TX_LOAD   = 4'd7,
        TX_WAIT   = 4'd8
    } state_t;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_CHK     = 8'h01;
    localparam logic [7:0] STAT_TMO     = 8'h02;
    localparam logic [7:0] STAT_SEL     = 8'h03;
    localparam int         STAT_OVR_BIT = 7;
    localparam int         FRAME_LEN    = 5;

    // Response frame: sync, status, rd hi, rd lo, xor checksum of the middle three.
    function automatic logic [7:0] resp_byte(input logic [2:0]  idx,
                                             input logic [7:0]  sync,
                                             input logic [7:0]  status,
                                             input logic [15:0] rd);
        case (idx)
            3'd0:    resp_byte = sync;
            3'd1:    resp_byte = status;
            3'd2:    resp_byte = rd[15:8];
            3'd3:    resp_byte = rd[7:0];
            default: resp_byte = status ^ rd[15:8] ^ rd[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_tx_ser.sv
// rtl/uart_cmd_tx_ser.sv - five-byte response serialiser with tx_en/tx_busy handshake
module uart_cmd_tx_ser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  status_i,
    input  logic [15:0] rdata_i,
    input  logic        tx_busy_i,
    output logic        tx_en_o,
    output logic [7:0]  tx_data_o,
    output logic        wait_o,
    output logic        done_o
);

    state_t      phase_q, phase_d;
    logic        skip_q, skip_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q   <= IDLE;
            skip_q    <= 1'b0;
            idx_q     <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            phase_q   <= phase_d;
            skip_q    <= skip_d;
            idx_q     <= idx_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        skip_d    = skip_q;
        idx_d     = idx_q;
        status_d  = status_q;
        rdata_d   = rdata_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        done_o    = 1'b0;
        case (phase_q)
            IDLE: begin
                if (start_i) begin
                    phase_d  = TX_LOAD;
                    idx_d    = '0;
                    status_d = status_i;
                    rdata_d  = rdata_i;
                end
            end
            TX_LOAD: begin
                if (!tx_busy_i) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = resp_byte(idx_q, SYNC_BYTE, status_q, rdata_q);
                    skip_d    = 1'b1;
                    phase_d   = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // tx_busy only rises the cycle after tx_en, so ignore the first wait cycle.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (!tx_busy_i) begin
                    if (idx_q == 3'(FRAME_LEN - 1)) begin
                        phase_d = IDLE;
                        done_o  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        phase_d = TX_LOAD;
                    end
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;
    assign wait_o    = (phase_q == TX_WAIT);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - UART command frame to CPU transaction sequencer
// Optional inter-byte gap abort: UART_CMD_RX_GAP_TIMEOUT_EN.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         CPU_TIMEOUT = 1024
`ifdef UART_CMD_RX_GAP_TIMEOUT_EN
    ,
    parameter int         RX_GAP_CYCLES = 4096
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        cpu_enable,
    output logic [1:0]  cpu_sel,
    output logic [15:0] cpu_wdata,
    input  logic        cpu_done,
    input  logic [15:0] cpu_rdata,
    output logic        busy,
    output logic        err
);

    localparam int CW = (CPU_TIMEOUT > 2) ? $clog2(CPU_TIMEOUT) : 1;

    state_t      state_q, state_d;
    logic [7:0]  sel_q, sel_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        cpu_en_q, cpu_en_d;
    logic [1:0]  cpu_sel_q, cpu_sel_d;
    logic [15:0] cpu_wdata_q, cpu_wdata_d;
    logic        ovr_q, ovr_d;
    logic        err_q, err_d;

    logic        resp_valid;
    logic [7:0]  resp_status;
    logic [15:0] resp_rd;
    logic        tx_start;
    logic [7:0]  tx_status;
    logic [15:0] tx_rdata;
    logic        ser_wait, ser_done;

`ifdef UART_CMD_RX_GAP_TIMEOUT_EN
    localparam int GW = $clog2(RX_GAP_CYCLES + 1);
    logic [GW-1:0] gap_q, gap_d;

    always_ff @(posedge clk) begin
        if (!reset) gap_q <= '0;
        else        gap_q <= gap_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            cpu_en_q    <= 1'b0;
            cpu_sel_q   <= '0;
            cpu_wdata_q <= '0;
            ovr_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            cpu_en_q    <= cpu_en_d;
            cpu_sel_q   <= cpu_sel_d;
            cpu_wdata_q <= cpu_wdata_d;
            ovr_q       <= ovr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        cpu_en_d    = 1'b0;
        cpu_sel_d   = cpu_sel_q;
        cpu_wdata_d = cpu_wdata_q;
        ovr_d       = ovr_q;
        err_d       = err_q;
        resp_valid  = 1'b0;
        resp_status = STAT_OK;
        resp_rd     = '0;
        tx_start    = 1'b0;
        tx_status   = STAT_OK;
        tx_rdata    = '0;
`ifdef UART_CMD_RX_GAP_TIMEOUT_EN
        gap_d       = gap_q;
`endif

        // A byte arriving while the link is occupied wins over the post-response clear.
        if (ser_done) ovr_d = 1'b0;
        if (rx_done && (state_q inside {CPU_START, CPU_WAIT, TX_LOAD, TX_WAIT})) ovr_d = 1'b1;

        case (state_q)
            IDLE:   if (rx_done && rx_data == SYNC_BYTE) state_d = RX_SEL;
            RX_SEL: if (rx_done) begin sel_d = rx_data; state_d = RX_HI;  end
            RX_HI:  if (rx_done) begin hi_d  = rx_data; state_d = RX_LO;  end
            RX_LO:  if (rx_done) begin lo_d  = rx_data; state_d = RX_CHK; end
            RX_CHK: begin
                if (rx_done) begin
                    if (rx_data != (sel_q ^ hi_q ^ lo_q)) begin
                        resp_valid  = 1'b1;
                        resp_status = STAT_CHK;
                    end else if (sel_q[7:2] != 6'd0) begin
                        resp_valid  = 1'b1;
                        resp_status = STAT_SEL;
                    end else begin
                        state_d     = CPU_START;
                        cpu_en_d    = 1'b1;
                        cpu_sel_d   = sel_q[1:0];
                        cpu_wdata_d = {hi_q, lo_q};
                    end
                end
            end
            CPU_START: begin
                cnt_d   = '0;
                state_d = CPU_WAIT;
            end
            CPU_WAIT: begin
                if (cpu_done) begin
                    resp_valid  = 1'b1;
                    resp_status = STAT_OK;
                    resp_rd     = cpu_rdata;
                end else if (cnt_q == CW'(CPU_TIMEOUT - 1)) begin
                    resp_valid  = 1'b1;
                    resp_status = STAT_TMO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_LOAD: if (ser_wait) state_d = TX_WAIT;
            TX_WAIT: begin
                if (ser_done)      state_d = IDLE;
                else if (!ser_wait) state_d = TX_LOAD;
            end
            default: state_d = IDLE;
        endcase

        if (resp_valid) begin
            tx_status                = resp_status;
            tx_status[STAT_OVR_BIT]  = resp_status[STAT_OVR_BIT] | ovr_d;
            tx_rdata                 = resp_rd;
            tx_start                 = 1'b1;
            state_d                  = TX_LOAD;
            if (tx_status != STAT_OK) err_d = 1'b1;
        end

`ifdef UART_CMD_RX_GAP_TIMEOUT_EN
        if (state_q inside {RX_SEL, RX_HI, RX_LO, RX_CHK}) begin
            if (rx_done) begin
                gap_d = '0;
            end else if (gap_q == GW'(RX_GAP_CYCLES - 1)) begin
                gap_d   = '0;
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end else begin
            gap_d = '0;
        end
`endif
    end

    uart_cmd_tx_ser #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_tx_ser (
        .clk       (clk),
        .reset     (reset),
        .start_i   (tx_start),
        .status_i  (tx_status),
        .rdata_i   (tx_rdata),
        .tx_busy_i (tx_busy),
        .tx_en_o   (tx_en),
        .tx_data_o (tx_data),
        .wait_o    (ser_wait),
        .done_o    (ser_done)
    );

    assign cpu_enable = cpu_en_q;
    assign cpu_sel    = cpu_sel_q;
    assign cpu_wdata  = cpu_wdata_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - scoreboard bench for uart_cmd_sequencer with randomized frames
module tb_uart_cmd_sequencer;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        cpu_done = 1'b0;
    logic [15:0] cpu_rdata = 16'h0000;
    logic        tx_en, cpu_enable, busy, err;
    logic [7:0]  tx_data;
    logic [1:0]  cpu_sel;
    logic [15:0] cpu_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_now = 0;
    int tx_count = 0;
    int cpu_en_count = 0;
    bit err_exp = 1'b0;

    logic [7:0]  exp_tx_q[$];
    logic [17:0] exp_cpu_q[$];
    int          cpu_delay_q[$];
    logic [15:0] cpu_rd_q[$];
    int          tx_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;
    always @(negedge clk) if (cpu_enable) cpu_en_count++;

    uart_cmd_sequencer #(.SYNC_BYTE(8'hA5), .CPU_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
        .cpu_enable(cpu_enable), .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    // Transmitter monitor: compares every launched byte, then models a busy period.
    initial forever begin
        @(negedge clk);
        if (tx_en) begin
            tx_count++;
            tx_cyc.push_back(cyc_now);
            check("tx_en_while_busy", 32'(tx_busy), 32'd0);
            if (exp_tx_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            @(posedge clk); #1 tx_busy = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
    end

    // CPU responder: checks the operation and answers after the scheduled delay (0 = never).
    initial forever begin
        logic [17:0] e;
        logic [15:0] rd;
        int          d;
        @(negedge clk);
        if (cpu_enable && exp_cpu_q.size() != 0) begin
            e  = exp_cpu_q.pop_front();
            d  = cpu_delay_q.pop_front();
            rd = cpu_rd_q.pop_front();
            check("cpu_sel", 32'(cpu_sel), 32'(e[17:16]));
            check("cpu_wdata", 32'(cpu_wdata), 32'(e[15:0]));
            if (d > 0) begin
                repeat (d) @(posedge clk);
                #1 cpu_done = 1'b1; cpu_rdata = rd;
                @(posedge clk);
                #1 cpu_done = 1'b0; cpu_rdata = 16'($urandom);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Reference model: the response depends only on frame fields, CPU delay and overrun.
    task automatic predict(input logic [7:0] sel, hi, lo, chk, input int delay,
                           input logic [15:0] rd, input bit ovr, output bit cpu_path);
        logic [7:0]  st;
        logic [15:0] r;
        cpu_path = 1'b0;
        r = 16'h0;
        if (chk != (sel ^ hi ^ lo))  st = 8'h01;
        else if (sel > 8'h03)        st = 8'h03;
        else begin
            cpu_path = 1'b1;
            exp_cpu_q.push_back({sel[1:0], hi, lo});
            cpu_delay_q.push_back(delay);
            cpu_rd_q.push_back(rd);
            if (delay >= 1 && delay <= TMO) begin st = 8'h00; r = rd; end
            else st = 8'h02;
        end
        if (ovr && cpu_path) st = st + 8'h80;
        exp_tx_q.push_back(8'hA5);
        exp_tx_q.push_back(st);
        exp_tx_q.push_back(r[15:8]);
        exp_tx_q.push_back(r[7:0]);
        exp_tx_q.push_back(st ^ r[15:8] ^ r[7:0]);
        if (st != 8'h00) err_exp = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] sel, hi, lo, chk, input int garbage, output int chk_cyc);
        logic [7:0] g;
        for (int i = 0; i < garbage; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
            idle($urandom_range(0, 1));
        end
        send_byte(8'hA5); idle($urandom_range(0, 2));
        send_byte(sel);   idle($urandom_range(0, 2));
        send_byte(hi);    idle($urandom_range(0, 2));
        send_byte(lo);    idle($urandom_range(0, 2));
        chk_cyc = cyc_now;
        send_byte(chk);
    endtask

    task automatic run_frame(input logic [7:0] sel, hi, lo, chk, input int delay,
                             input logic [15:0] rd, input bit ovr, input int garbage);
        bit cpu_path;
        int chk_cyc;
        int en_before;
        int cnt;
        en_before = cpu_en_count;
        tx_cyc.delete();
        predict(sel, hi, lo, chk, delay, rd, ovr, cpu_path);
        send_frame(sel, hi, lo, chk, garbage, chk_cyc);
        if (ovr) begin
            idle(1);
            send_byte(8'($urandom));
        end
        cnt = 0;
        while ((busy || exp_tx_q.size() != 0) && cnt < 3000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("frame_complete", 32'(busy), 32'd0);
        check("tx_bytes_left", 32'(exp_tx_q.size()), 32'd0);
        check("cpu_enable_count", 32'(cpu_en_count - en_before), 32'(cpu_path));
        check("err", 32'(err), 32'(err_exp));
        if (!cpu_path && tx_cyc.size() != 0)
            check("tx_first_latency", 32'(tx_cyc[0] - chk_cyc), 32'd2);
        exp_tx_q.delete();
        exp_cpu_q.delete();
        cpu_delay_q.delete();
        cpu_rd_q.delete();
        idle($urandom_range(0, 3));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s, h, l, c;
        int kind, base, cnt, chk_cyc;
        bit cpu_path;

        idle(3);
        check("reset_tx_en", 32'(tx_en), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        check("reset_cpu_enable", 32'(cpu_enable), 32'd0);
        check("reset_cpu_sel", 32'(cpu_sel), 32'd0);
        check("reset_cpu_wdata", 32'(cpu_wdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b1;
        idle(2);

        run_frame(8'h01, 8'h12, 8'h34, 8'h27, 10, 16'hBEEF, 1'b0, 2);
        run_frame(8'h01, 8'h12, 8'h34, 8'h00, 10, 16'h0000, 1'b0, 0);
        run_frame(8'h04, 8'h00, 8'h00, 8'h04, 10, 16'h0000, 1'b0, 1);
        run_frame(8'h02, 8'hC0, 8'hDE, 8'h1C, 0,  16'h1111, 1'b0, 0);
        run_frame(8'h03, 8'h55, 8'hAA, 8'hFC, 16, 16'hCAFE, 1'b0, 0);
        run_frame(8'h00, 8'h01, 8'h02, 8'h03, 17, 16'h2222, 1'b0, 0);
        run_frame(8'h01, 8'h12, 8'h34, 8'h27, 9,  16'h1357, 1'b1, 0);

        // Reset during the response, after byte 2 has been launched.
        base = tx_count;
        predict(8'h01, 8'h12, 8'h34, 8'h27, 5, 16'hBEEF, 1'b0, cpu_path);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27, 0, chk_cyc);
        cnt = 0;
        while (tx_count < base + 3 && cnt < 2000) begin @(posedge clk); #1; cnt++; end
        check("reached_tx_byte2", 32'(tx_count - base), 32'd3);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_tx_en", 32'(tx_en), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        exp_tx_q.delete();
        exp_cpu_q.delete();
        cpu_delay_q.delete();
        cpu_rd_q.delete();
        err_exp = 1'b0;
        idle(6);
        run_frame(8'h01, 8'h12, 8'h34, 8'h27, 10, 16'hBEEF, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            s = {6'd0, 2'($urandom)};
            h = 8'($urandom);
            l = 8'($urandom);
            c = s ^ h ^ l;
            case (kind)
                0: run_frame(s, h, l, c, $urandom_range(1, TMO), 16'($urandom), 1'b0, $urandom_range(0, 2));
                1: run_frame(8'($urandom), h, l, c ^ 8'($urandom_range(1, 255)), 3, 16'($urandom), 1'b0, 0);
                2: begin
                    s = {6'($urandom_range(1, 63)), 2'($urandom)};
                    run_frame(s, h, l, s ^ h ^ l, 3, 16'($urandom), 1'b0, 1);
                end
                3: run_frame(s, h, l, c, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(TMO + 1, TMO + 4),
                             16'($urandom), 1'b0, 0);
                4: run_frame(s, h, l, c, $urandom_range(1, TMO), 16'($urandom), 1'b1, 0);
                default: run_frame(s, h, l, c, $urandom_range(TMO - 1, TMO), 16'($urandom), 1'b0, 0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
